// File: rtl/rect_blitter.sv
`default_nettype none
// =============================================================================
// rect_blitter : clipped rectangle-fill engine, one framebuffer write per clock
// Optional pixel counter: BLIT_PIXCOUNT_EN | Rev 1.0
// =============================================================================
module rect_blitter #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  input  logic              cmd_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        dataIn,
  output logic              swap_req,
  input  logic              swap_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] pix_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_SWAP = 2'd2
  } state_t;

  localparam logic [9:0]        c_h_res   = 10'(H_RES);
  localparam logic [8:0]        c_v_res   = 9'(V_RES);
  localparam logic [ADDR_W-1:0] c_row_inc = ADDR_W'(H_RES);

  state_t            r_state, w_next_state;
  logic [8:0]        r_x0, r_x_end, r_col;
  logic [7:0]        r_y_end, r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_last;

  logic [9:0]        w_x_sum;
  logic [8:0]        w_y_sum;
  logic [8:0]        w_x_end;
  logic [7:0]        w_y_end;
  logic              w_empty, w_accept, w_col_last, w_row_last;
  logic [ADDR_W-1:0] w_cmd_base;

  // One extra bit on the sums so far-edge clipping never wraps
  assign w_x_sum    = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign w_y_sum    = {1'b0, cmd_y} + {1'b0, cmd_h};
  assign w_x_end    = (w_x_sum > c_h_res) ? c_h_res[8:0] : w_x_sum[8:0];
  assign w_y_end    = (w_y_sum > c_v_res) ? c_v_res[7:0] : w_y_sum[7:0];
  assign w_empty    = (cmd_w == 9'd0) || (cmd_h == 8'd0) ||
                      ({1'b0, cmd_x} >= c_h_res) || ({1'b0, cmd_y} >= c_v_res);
  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_col_last = (r_col + 9'd1) == r_x_end;
  assign w_row_last = (r_row + 8'd1) == r_y_end;
  // y*320 as y*256 + y*64, no multiplier
  assign w_cmd_base = (ADDR_W'(cmd_y) << 8) + (ADDR_W'(cmd_y) << 6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    swap_req     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (w_accept) begin
          if (w_empty) w_next_state = cmd_last ? S_SWAP : S_IDLE;
          else         w_next_state = S_DRAW;
        end
      end
      S_DRAW: begin
        busy = 1'b1;
        if (w_col_last && w_row_last) w_next_state = r_last ? S_SWAP : S_IDLE;
      end
      S_SWAP: begin
        busy     = 1'b1;
        swap_req = 1'b1;
        if (swap_ack) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      address    <= '0;
      dataIn     <= 8'd0;
      r_x0       <= 9'd0;
      r_x_end    <= 9'd0;
      r_col      <= 9'd0;
      r_y_end    <= 8'd0;
      r_row      <= 8'd0;
      r_row_base <= '0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_empty) begin
            r_x0       <= cmd_x;
            r_x_end    <= w_x_end;
            r_y_end    <= w_y_end;
            r_col      <= cmd_x;
            r_row      <= cmd_y;
            r_row_base <= w_cmd_base;
            r_last     <= cmd_last;
            address    <= w_cmd_base + ADDR_W'(cmd_x);
            dataIn     <= cmd_color;
            wr_en      <= 1'b1;
          end
        end
        S_DRAW: begin
          if (w_col_last) begin
            if (w_row_last) begin
              wr_en <= 1'b0;
            end else begin
              r_col      <= r_x0;
              r_row      <= r_row + 8'd1;
              r_row_base <= r_row_base + c_row_inc;
              address    <= r_row_base + c_row_inc + ADDR_W'(r_x0);
            end
          end else begin
            r_col   <= r_col + 9'd1;
            address <= r_row_base + ADDR_W'(r_col + 9'd1);
          end
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

`ifdef BLIT_PIXCOUNT_EN
  logic [ADDR_W-1:0] r_pix_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_pix_count <= '0;
    else if (r_state == S_SWAP && swap_ack)  r_pix_count <= '0;
    else if (wr_en && (r_pix_count != '1))   r_pix_count <= r_pix_count + 1'b1;
  end

  assign pix_count = r_pix_count;
`else
  assign pix_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rect_blitter.sv
`default_nettype none
// =============================================================================
// tb_rect_blitter : scoreboard bench for rect_blitter | Rev 1.0
// =============================================================================
module tb_rect_blitter;
  localparam int H  = 320;
  localparam int V  = 240;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [8:0]    cmd_x = '0;
  logic [7:0]    cmd_y = '0;
  logic [8:0]    cmd_w = '0;
  logic [7:0]    cmd_h = '0;
  logic [7:0]    cmd_color = '0;
  logic          cmd_last = 1'b0;
  logic          wr_en;
  logic [AW-1:0] address;
  logic [7:0]    dataIn;
  logic          swap_req;
  logic          swap_ack = 1'b0;
  logic          busy;
  logic [AW-1:0] pix_count;

  always #5 clk = ~clk;

  rect_blitter #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_last(cmd_last),
    .wr_en(wr_en), .address(address), .dataIn(dataIn),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .busy(busy), .pix_count(pix_count)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_writes = 0;
  int            exp_pix  = 0;
  logic [AW-1:0] last_addr = '0;
  logic [27:0]   sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] pix_exp();
`ifdef BLIT_PIXCOUNT_EN
    return 32'(exp_pix);
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: actual addr=%0d data=%0h required no write", address, dataIn);
      end else begin
        logic [27:0] e;
        e = sb.pop_front();
        chk("write_addr_data", {4'd0, address, dataIn}, {4'd0, e});
      end
      last_addr = address;
      n_writes++;
    end
  end

  task automatic push_rect(input int x, input int y, input int w, input int h, input logic [7:0] c);
    int xe, ye;
    logic [AW-1:0] a;
    xe = (x + w > H) ? H : x + w;
    ye = (y + h > V) ? V : y + h;
    for (int r = y; r < ye; r++) begin
      for (int cc = x; cc < xe; cc++) begin
        a = 20'(r * H + cc);
        sb.push_back({a, c});
        exp_pix++;
      end
    end
  endtask

  task automatic send_cmd(input int x, input int y, input int w, input int h,
                          input logic [7:0] c, input logic l);
    int t;
    @(negedge clk);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
    cmd_color = c; cmd_last = l; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail("cmd_ready_wait");
    push_rect(x, y, w, h, c);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int t;
    t = 0;
    while ((sb.size() != 0 || cmd_ready !== 1'b1) && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (t >= bound) timeout_fail("drain_wait");
  endtask

  task automatic wait_swap(input int bound);
    int t;
    t = 0;
    while (swap_req !== 1'b1 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (t >= bound) timeout_fail("swap_req_wait");
  endtask

  task automatic do_ack();
    @(negedge clk);
    swap_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("swap_req_after_ack", 32'(swap_req), 32'd0);
    chk("ready_after_ack", 32'(cmd_ready), 32'd1);
    exp_pix = 0;
    chk("pix_after_ack", 32'(pix_count), pix_exp());
    @(negedge clk);
    swap_ack = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_dataIn", 32'(dataIn), 32'd0);
    chk("rst_swap_req", 32'(swap_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pix_count", 32'(pix_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 4x2 fill at origin
    n_writes = 0;
    send_cmd(0, 0, 4, 2, 8'hE0, 1'b0);
    chk("busy_in_draw", 32'(busy), 32'd1);
    chk("ready_in_draw", 32'(cmd_ready), 32'd0);
    wait_drain(100);
    chk("t1_writes", 32'(n_writes), 32'd8);
    chk("t1_last_addr", 32'(last_addr), 32'd323);

    // swap_ack while idle has no effect
    @(negedge clk); swap_ack = 1'b1;
    @(negedge clk); swap_ack = 1'b0;
    chk("idle_ack_pix", 32'(pix_count), pix_exp());
    chk("idle_ack_ready", 32'(cmd_ready), 32'd1);

    // Bottom-right corner clip
    n_writes = 0;
    send_cmd(318, 239, 10, 5, 8'h1C, 1'b0);
    wait_drain(100);
    chk("t2_writes", 32'(n_writes), 32'd2);
    chk("t2_last_addr", 32'(last_addr), 32'd76799);

    // Empty commands
    n_writes = 0;
    send_cmd(400, 10, 5, 5, 8'h55, 1'b0);
    chk("empty_x_ready", 32'(cmd_ready), 32'd1);
    chk("empty_x_wr_en", 32'(wr_en), 32'd0);
    send_cmd(20, 20, 0, 5, 8'h55, 1'b0);
    chk("empty_w_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    chk("empty_writes", 32'(n_writes), 32'd0);

    // Single pixel with swap, held off for 20 cycles
    n_writes = 0;
    send_cmd(10, 10, 1, 1, 8'hA5, 1'b1);
    wait_swap(50);
    chk("t4_writes", 32'(n_writes), 32'd1);
    chk("t4_last_addr", 32'(last_addr), 32'd3210);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_pix_before_ack", 32'(pix_count), pix_exp());
    cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd2; cmd_h = 8'd2; cmd_last = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("swap_wait_ready", 32'(cmd_ready), 32'd0);
    end
    chk("swap_req_held", 32'(swap_req), 32'd1);
    swap_ack = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_swap_req_after_ack", 32'(swap_req), 32'd0);
    chk("t4_ready_after_ack", 32'(cmd_ready), 32'd1);
    exp_pix = 0;
    @(negedge clk);
    chk("t4_pix_after_ack", 32'(pix_count), pix_exp());

    // Empty last command, ack already high: honoured in first SWAP_WAIT cycle
    send_cmd(0, 0, 0, 0, 8'h00, 1'b1);
    chk("t5_swap_req", 32'(swap_req), 32'd1);
    @(posedge clk);
    #1;
    chk("t5_swap_done", 32'(swap_req), 32'd0);
    chk("t5_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    swap_ack = 1'b0;

    // Reset during the 3rd write of a 4x4 fill
    n_writes = 0;
    send_cmd(100, 50, 4, 4, 8'h3C, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_swap_req", 32'(swap_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pix", 32'(pix_count), 32'd0);
    chk("midrst_writes", 32'(n_writes), 32'd2);
    sb.delete();
    exp_pix = 0;
    @(negedge clk);
    rst = 1'b0;
    n_writes = 0;
    send_cmd(5, 3, 2, 2, 8'hC3, 1'b1);
    wait_swap(50);
    chk("post_rst_writes", 32'(n_writes), 32'd4);
    chk("post_rst_last_addr", 32'(last_addr), 32'd1286);
    chk("post_rst_pix", 32'(pix_count), pix_exp());
    do_ack();

    // Full-screen fill
    n_writes = 0;
    send_cmd(0, 0, 320, 240, 8'h92, 1'b1);
    wait_swap(80000);
    chk("full_writes", 32'(n_writes), 32'd76800);
    chk("full_last_addr", 32'(last_addr), 32'd76799);
    chk("full_pix", 32'(pix_count), pix_exp());
    do_ack();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
